// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit path: FSM state encoding and default sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each half-period.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  // restart realigns the count with a state change so every phase starts a full half-period
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_tx_frame.sv
// SPI mode-0 frame transmitter: accepts one word per valid/ready handshake and shifts it out MSB first.
module spi_tx_frame
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi
);

  localparam logic [4:0] LAST_BIT = 5'(DATA_W);

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              tick;
  logic              restart;

  always_comb begin
    restart = 1'b0;
    if (state == IDLE) begin
      restart = tx_valid && tx_ready;
    end else begin
      restart = tick;
    end
  end

  spi_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= SETUP;
            shreg    <= tx_data;
            mosi     <= tx_data[DATA_W-1];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state   <= SHIFT;
            sclk    <= 1'b1;
            bit_cnt <= 5'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              sclk <= 1'b0;
              // after the last rising edge mosi keeps the LSB through HOLD
              if (bit_cnt != LAST_BIT) begin
                shreg <= {shreg[DATA_W-2:0], shreg[DATA_W-1]};
                mosi  <= shreg[DATA_W-2];
              end
            end else if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
            mosi     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
